aoi_sweep_ctrl: RTL and testbench

- Exhaustive test sequencer for a 5-input switch-level AOI cell implementing F = ~((A&B)|(C&D&E)).
- On start, drives all 32 input vectors into the cell, waits a settle interval, samples F, and compares it against a built-in golden function.
- Reports pass/fail, mismatch count and the first failing vector.
- Sits beside the transistor-level cell as its on-chip self-check controller.

---
 rtl/aoi_sweep_ctrl_pkg.sv | 31 +++
 rtl/aoi_sweep_ctrl_if.sv | 35 +++
 rtl/aoi_settle_timer.sv | 35 +++
 rtl/aoi_sweep_ctrl.sv | 139 +++++++++++++
 tb/tb_aoi_sweep_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aoi_sweep_ctrl_pkg.sv
// +------------------------------------------------------------------------+
// | Module   : aoi_pkg                                                     |
// | Brief    : Shared constants and golden model for the AOI cell sweeper. |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

package aoi_pkg;

  // Sweeper state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SAMPLE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam int N_VEC    = 32;
  localparam int VEC_W    = 5;
  localparam int ERR_W    = 6;
  localparam int SETTLE_W = 4;

  typedef logic [2:0] state_t;

  // Expected cell response: F = ~((A&B)|(C&D&E)), A is bit 4
  function automatic logic aoi_golden(input logic [VEC_W-1:0] v);
    return ~((v[4] & v[3]) | (v[2] & v[1] & v[0]));
  endfunction

endpackage

`default_nettype wire

// File: rtl/aoi_sweep_ctrl_if.sv
// +------------------------------------------------------------------------+
// | Module   : aoi_sweep_ctrl_if                                           |
// | Brief    : Control, status and cell-facing signals of the AOI sweeper. |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

interface aoi_sweep_ctrl_if;
  import aoi_pkg::*;

  logic              start;
  logic [VEC_W-1:0]  dut_in;
  logic              dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [VEC_W-1:0]  first_fail_vec;
  logic              first_fail_valid;

  // Sweeper side
  modport master (
    input  start, dut_out,
    output dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

  // Requester / cell side
  modport slave (
    output start, dut_out,
    input  dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
  );

endinterface

`default_nettype wire

// File: rtl/aoi_settle_timer.sv
// +------------------------------------------------------------------------+
// | Module   : aoi_settle_timer                                            |
// | Brief    : Loadable down-counter with zero flag for settle intervals.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module aoi_settle_timer #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  input  wire logic             en,
  output logic      [WIDTH-1:0] count,
  output logic                  zero
);

  // Load has priority; decrement stops at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (count == '0);

endmodule

`default_nettype wire

// File: rtl/aoi_sweep_ctrl.sv
// +------------------------------------------------------------------------+
// | Module   : aoi_sweep_ctrl                                              |
// | Brief    : Exhaustive 32-vector self-check sequencer for a 5-input AOI |
// |            cell. Optional macro AOI_SWEEP_STOP_ON_FAIL_EN ends the     |
// |            sweep at the first mismatch.                                |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module aoi_sweep_ctrl
  import aoi_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int N_IN          = 5
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  aoi_sweep_ctrl_if.master  bus
);

  localparam logic [N_IN-1:0]     LAST_VEC    = {N_IN{1'b1}};
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

  state_t              r_state;
  logic [VEC_W-1:0]    r_vec;
  logic [VEC_W-1:0]    r_dut_in;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [ERR_W-1:0]    r_err;
  logic [VEC_W-1:0]    r_ff_vec;
  logic                r_ff_valid;

  logic [SETTLE_W-1:0] w_cnt;
  logic                w_cnt_zero;
  logic                w_settle_last;
  logic                w_golden;
  logic                w_mismatch;
  logic                w_last_vec;
  logic                w_stop;
  logic [ERR_W-1:0]    w_err_next;

  aoi_settle_timer #(
    .WIDTH (SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (r_state == ST_DRIVE),
    .load_val (SETTLE_LOAD),
    .en       (r_state == ST_SETTLE),
    .count    (w_cnt),
    .zero     (w_cnt_zero)
  );

  // Sample-time comparison and sweep termination decision
  always_comb begin
    w_golden      = aoi_golden(r_vec);
    // Case-inequality so an undriven or unknown cell output is a mismatch
    w_mismatch    = (bus.dut_out !== w_golden);
    w_err_next    = r_err + {{(ERR_W-1){1'b0}}, w_mismatch};
    w_last_vec    = (r_vec == LAST_VEC);
    // Zero guard keeps the FSM from stalling if the counter is ever empty
    w_settle_last = (w_cnt == SETTLE_W'(1)) || w_cnt_zero;
`ifdef AOI_SWEEP_STOP_ON_FAIL_EN
    w_stop        = w_last_vec || w_mismatch;
`else
    w_stop        = w_last_vec;
`endif
  end

  // Sweep sequencer and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_vec      <= '0;
      r_dut_in   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_ff_vec   <= '0;
      r_ff_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state    <= ST_DRIVE;
            r_vec      <= '0;
            r_err      <= '0;
            r_ff_vec   <= '0;
            r_ff_valid <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_DRIVE: begin
          r_dut_in <= r_vec;
          r_state  <= (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_SAMPLE;
        end
        ST_SETTLE: begin
          if (w_settle_last) begin
            r_state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_ff_valid) begin
            r_ff_vec   <= r_vec;
            r_ff_valid <= 1'b1;
          end
          if (w_stop) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_vec   <= r_vec + {{(VEC_W-1){1'b0}}, 1'b1};
            r_state <= ST_DRIVE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dut_in           = r_dut_in;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.pass             = r_pass;
  assign bus.err_count        = r_err;
  assign bus.first_fail_vec   = r_ff_vec;
  assign bus.first_fail_valid = r_ff_valid;

endmodule

`default_nettype wire

// File: tb/tb_aoi_sweep_ctrl.sv
// +------------------------------------------------------------------------+
// | Module   : tb_aoi_sweep_ctrl                                           |
// | Brief    : Directed bench for aoi_sweep_ctrl with several cell models; |
// |            expectations follow AOI_SWEEP_STOP_ON_FAIL_EN when defined. |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_aoi_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // 0: good, 1: stuck-at-1, 2: inverted, 3: good with two-cycle delay
  int   mode0 = 0;
  int   mode1 = 0;
  logic slow1, slow2;

  always #5 clk = ~clk;

  aoi_sweep_ctrl_if if0();
  aoi_sweep_ctrl_if if1();

  aoi_sweep_ctrl #(.SETTLE_CYCLES(2), .N_IN(5)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  aoi_sweep_ctrl #(.SETTLE_CYCLES(0), .N_IN(5)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  function automatic logic ref_f(input logic [4:0] v);
    return ~((v[4] & v[3]) | (v[2] & v[1] & v[0]));
  endfunction

  // Delayed cell: output follows its inputs two clock edges late
  always @(posedge clk) begin
    slow1 <= ref_f(if0.dut_in);
    slow2 <= slow1;
  end

  always_comb begin
    case (mode0)
      1:       if0.dut_out = 1'b1;
      2:       if0.dut_out = ~ref_f(if0.dut_in);
      3:       if0.dut_out = slow2;
      default: if0.dut_out = ref_f(if0.dut_in);
    endcase
  end

  always_comb begin
    case (mode1)
      1:       if1.dut_out = 1'b1;
      2:       if1.dut_out = ~ref_f(if1.dut_in);
      default: if1.dut_out = ref_f(if1.dut_in);
    endcase
  end

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) if0.start = v;
    else          if1.start = v;
  endtask

  task automatic get_st(input int sel, output logic b, output logic d, output logic p,
                        output logic [5:0] e, output logic [4:0] fv, output logic fok,
                        output logic [4:0] di);
    if (sel == 0) begin
      b = if0.busy; d = if0.done; p = if0.pass; e = if0.err_count;
      fv = if0.first_fail_vec; fok = if0.first_fail_valid; di = if0.dut_in;
    end else begin
      b = if1.busy; d = if1.done; p = if1.pass; e = if1.err_count;
      fv = if1.first_fail_vec; fok = if1.first_fail_valid; di = if1.dut_in;
    end
  endtask

  // Pulse start and count edges (accept edge = 1) until done; optional extra pulse
  task automatic run_sweep(input int sel, input int pulse_at, output int cycles, output logic busy1);
    logic b, d, p, fok;
    logic [5:0] e;
    logic [4:0] fv, di;
    @(posedge clk); #1;
    set_start(sel, 1'b1);
    cycles = 0;
    busy1  = 1'b0;
    d      = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      cycles++;
      get_st(sel, b, d, p, e, fv, fok, di);
      if (cycles == 1) begin
        set_start(sel, 1'b0);
        busy1 = b;
      end
      if (pulse_at > 0 && cycles == pulse_at)     set_start(sel, 1'b1);
      if (pulse_at > 0 && cycles == pulse_at + 1) set_start(sel, 1'b0);
      if (d) break;
    end
    checks++;
    if (d !== 1'b1) begin
      errors++;
      $display("FAIL sweep_timeout: done=%b after %0d cycles, required done=1", d, cycles);
    end
  endtask

  task automatic test_reset;
    logic b, d, p, fok;
    logic [5:0] e;
    logic [4:0] fv, di;
    if0.start = 1'b0;
    if1.start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      get_st(s, b, d, p, e, fv, fok, di);
      checks++;
      if ({b, d, p, e, fv, fok, di} !== 19'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: busy=%b done=%b pass=%b err=%0d ffv=%h ffok=%b din=%h, required all 0",
                 s, b, d, p, e, fv, fok, di);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_good;
    int cyc;
    logic b1, b, d, p, fok;
    logic [5:0] e;
    logic [4:0] fv, di;
    mode0 = 3;
    run_sweep(0, 0, cyc, b1);
    get_st(0, b, d, p, e, fv, fok, di);
    checks++;
    if (b1 !== 1'b1) begin errors++; $display("FAIL good_busy_after_accept: got %b want 1", b1); end
    checks++;
    if (cyc != 129) begin errors++; $display("FAIL good_latency: got %0d want 129", cyc); end
    checks++;
    if ({b, p, e, fok} !== {1'b0, 1'b1, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL good_result: busy=%b pass=%b err=%0d ffok=%b, required 0 1 0 0", b, p, e, fok);
    end
    checks++;
    if (di !== 5'h1f) begin errors++; $display("FAIL good_dut_in_hold: got %h want 1f", di); end
  endtask

  task automatic test_stuck1;
    int cyc;
    logic b1, b, d, p, fok;
    logic [5:0] e;
    logic [4:0] fv, di;
    int exp_err, exp_cyc;
    logic [4:0] exp_di;
`ifdef AOI_SWEEP_STOP_ON_FAIL_EN
    exp_err = 1;  exp_cyc = 33;  exp_di = 5'h07;
`else
    // golden is 0 on 18..1F and on 07, 0F, 17 -> 11 vectors
    exp_err = 11; exp_cyc = 129; exp_di = 5'h1f;
`endif
    mode0 = 1;
    run_sweep(0, 0, cyc, b1);
    get_st(0, b, d, p, e, fv, fok, di);
    checks++;
    if (e !== 6'(exp_err)) begin errors++; $display("FAIL stuck1_err_count: got %0d want %0d", e, exp_err); end
    checks++;
    if ({fok, fv} !== {1'b1, 5'h07}) begin
      errors++; $display("FAIL stuck1_first_fail: valid=%b vec=%h, required 1 07", fok, fv);
    end
    checks++;
    if (p !== 1'b0) begin errors++; $display("FAIL stuck1_pass: got %b want 0", p); end
    checks++;
    if (cyc != exp_cyc) begin errors++; $display("FAIL stuck1_latency: got %0d want %0d", cyc, exp_cyc); end
    checks++;
    if (di !== exp_di) begin errors++; $display("FAIL stuck1_dut_in: got %h want %h", di, exp_di); end
  endtask

  task automatic test_inverted;
    int cyc;
    logic b1, b, d, p, fok;
    logic [5:0] e;
    logic [4:0] fv, di;
    int exp_err, exp_cyc;
`ifdef AOI_SWEEP_STOP_ON_FAIL_EN
    exp_err = 1;  exp_cyc = 5;
`else
    exp_err = 32; exp_cyc = 129;
`endif
    mode0 = 2;
    run_sweep(0, 0, cyc, b1);
    get_st(0, b, d, p, e, fv, fok, di);
    checks++;
    if (e !== 6'(exp_err)) begin errors++; $display("FAIL inv_err_count: got %0d want %0d", e, exp_err); end
    checks++;
    if ({fok, fv, p} !== {1'b1, 5'h00, 1'b0}) begin
      errors++; $display("FAIL inv_first_fail: valid=%b vec=%h pass=%b, required 1 00 0", fok, fv, p);
    end
    checks++;
    if (cyc != exp_cyc) begin errors++; $display("FAIL inv_latency: got %0d want %0d", cyc, exp_cyc); end
  endtask

  task automatic test_settle0;
    int cyc;
    logic b1, b, d, p, fok;
    logic [5:0] e;
    logic [4:0] fv, di;
    mode1 = 0;
    run_sweep(1, 20, cyc, b1);
    get_st(1, b, d, p, e, fv, fok, di);
    checks++;
    if (cyc != 65) begin errors++; $display("FAIL settle0_latency: got %0d want 65", cyc); end
    checks++;
    if ({p, e, fok, di} !== {1'b1, 6'd0, 1'b0, 5'h1f}) begin
      errors++;
      $display("FAIL settle0_result: pass=%b err=%0d ffok=%b din=%h, required 1 0 0 1f", p, e, fok, di);
    end
  endtask

  task automatic test_async_reset;
    int cyc;
    logic b1, b, d, p, fok;
    logic [5:0] e;
    logic [4:0] fv, di;
    mode0 = 1;
    @(posedge clk); #1;
    if0.start = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(posedge clk); #1;
      if0.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    get_st(0, b, d, p, e, fv, fok, di);
    checks++;
    if ({b, d, p, e, fv, fok, di} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b pass=%b err=%0d ffv=%h ffok=%b din=%h, required all 0",
               b, d, p, e, fv, fok, di);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mode0 = 3;
    run_sweep(0, 0, cyc, b1);
    get_st(0, b, d, p, e, fv, fok, di);
    checks++;
    if (cyc != 129 || p !== 1'b1 || e !== 6'd0) begin
      errors++;
      $display("FAIL post_reset_sweep: cycles=%0d pass=%b err=%0d, required 129 1 0", cyc, p, e);
    end
  endtask

  task automatic test_back_to_back;
    int c;
    logic d_after;
    mode1 = 0;
    @(posedge clk); #1;
    if1.start = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (if1.done) break;
    end
    c = 0;
    d_after = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) d_after = if1.done;
      if (if1.done) break;
    end
    checks++;
    if (d_after !== 1'b0) begin errors++; $display("FAIL b2b_done_width: done=%b one cycle later, want 0", d_after); end
    checks++;
    if (c != 65) begin errors++; $display("FAIL b2b_restart_period: got %0d want 65", c); end
    @(posedge clk); #1;
    if1.start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (if1.done) break;
    end
    checks++;
    if (if1.done !== 1'b1 || if1.pass !== 1'b1) begin
      errors++; $display("FAIL b2b_final: done=%b pass=%b, required 1 1", if1.done, if1.pass);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_stuck1();
    test_inverted();
    test_settle0();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
